// File: rtl/jk_bank_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : jk_bank_seq
// Description : Command-driven sequencer for a bank of WIDTH JK flip-flops.
//               It accepts one command at a time over a valid/ready handshake.
//               It drives the bank j/k pins to load, set, clear, toggle, count
//               or shift the bank, and signals completion with a one-cycle
//               done pulse.
//
// Ports       : clk        - clock; the bank samples j/k on its rising edge
//               rst        - asynchronous active-high reset, shared with bank
//               cmd_valid  - command present
//               cmd_ready  - command can be accepted (IDLE only)
//               cmd_op     - 0 NOP, 1 LOAD, 2 CLEAR, 3 SET, 4 TOGGLE,
//                            5 COUNT, 6 SHIFT, 7 reserved
//               cmd_data   - load value / toggle mask / shift-in bit [0]
//               cmd_count  - repeat count for COUNT/SHIFT
//               q_in       - bank Q outputs
//               j_out      - bank j drives
//               k_out      - bank k drives
//               busy       - high in RUN and DONE
//               done       - one-cycle completion pulse
//               err        - one-cycle pulse with done for unsupported opcode
//
// Build macro : JK_BANK_SEQ_SHIFT_EN - when defined, op 6 shifts the bank
//               left. When it is undefined, op 6 is treated as reserved.
//
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module jk_bank_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [2:0] c_OP_NOP    = 3'd0;
   localparam logic [2:0] c_OP_LOAD   = 3'd1;
   localparam logic [2:0] c_OP_CLEAR  = 3'd2;
   localparam logic [2:0] c_OP_SET    = 3'd3;
   localparam logic [2:0] c_OP_TOGGLE = 3'd4;
   localparam logic [2:0] c_OP_COUNT  = 3'd5;
   localparam logic [2:0] c_OP_SHIFT  = 3'd6;
   localparam logic [2:0] c_OP_RSVD   = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_data;
   logic [CNT_W-1:0] r_cnt;

   logic             w_accept;
   logic             w_direct;      // accepted command completes without RUN
   logic             w_repeat_op;   // op takes its repeat count from cmd_count
   logic             w_unsup;       // latched op is not supported
   logic [WIDTH-1:0] w_cnt_en;      // per-cell toggle enable of the up-counter

   // Counter cell i toggles when all lower cells are 1. Driven from the
   // registered q_in, so there is no combinational loop through the bank.
   assign w_cnt_en[0] = 1'b1;
   generate
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_cnt_en
         assign w_cnt_en[gi] = &q_in[gi-1:0];
      end
   endgenerate

`ifdef JK_BANK_SEQ_SHIFT_EN
   logic [WIDTH-1:0] w_shift_val;   // value the bank takes after one shift
   assign w_shift_val = {q_in[WIDTH-2:0], r_data[0]};
   assign w_repeat_op = (cmd_op == c_OP_COUNT) || (cmd_op == c_OP_SHIFT);
   assign w_unsup     = (r_op == c_OP_RSVD);
   assign w_direct    = (cmd_op == c_OP_NOP) || (cmd_op == c_OP_RSVD) ||
                        (w_repeat_op && (cmd_count == '0));
`else
   assign w_repeat_op = (cmd_op == c_OP_COUNT);
   assign w_unsup     = (r_op == c_OP_RSVD) || (r_op == c_OP_SHIFT);
   assign w_direct    = (cmd_op == c_OP_NOP) || (cmd_op == c_OP_RSVD) ||
                        (cmd_op == c_OP_SHIFT) ||
                        (w_repeat_op && (cmd_count == '0));
`endif

   assign w_accept = (r_state == S_IDLE) && cmd_valid;

   // State and command registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_data  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op   <= cmd_op;
            r_data <= cmd_data;
            r_cnt  <= w_repeat_op ? cmd_count : CNT_W'(1);
         end else if (r_state == S_RUN) begin
            r_cnt  <= r_cnt - CNT_W'(1);
         end
      end
   end

   // Next state and outputs
   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      j_out       = '0;
      k_out       = '0;

      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_state_nxt = w_direct ? S_DONE : S_RUN;
            end
         end

         S_RUN: begin
            busy = 1'b1;
            case (r_op)
               c_OP_LOAD: begin
                  j_out = r_data;
                  k_out = ~r_data;
               end
               c_OP_CLEAR: begin
                  k_out = '1;
               end
               c_OP_SET: begin
                  j_out = '1;
               end
               c_OP_TOGGLE: begin
                  j_out = r_data;
                  k_out = r_data;
               end
               c_OP_COUNT: begin
                  j_out = w_cnt_en;
                  k_out = w_cnt_en;
               end
`ifdef JK_BANK_SEQ_SHIFT_EN
               c_OP_SHIFT: begin
                  j_out = w_shift_val;
                  k_out = ~w_shift_val;
               end
`endif
               default: begin
                  j_out = '0;
                  k_out = '0;
               end
            endcase
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = S_DONE;
            end
         end

         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            err         = w_unsup;
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_jk_bank_seq
// Description : Self-checking bench for jk_bank_seq with an 8-cell JK bank
//               modelled alongside the DUT. A table of single commands is
//               applied in a loop. Hand-written sequences then cover COUNT
//               step-by-step, a command held while busy, and reset mid-RUN.
//
// Build macro : JK_BANK_SEQ_SHIFT_EN selects the expected SHIFT outcome.
//
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_jk_bank_seq;

   localparam int WIDTH = 8;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_count;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] j_out;
   logic [WIDTH-1:0] k_out;
   logic             busy;
   logic             done;
   logic             err;

   int checks = 0;
   int errors = 0;

   jk_bank_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_count (cmd_count),
      .q_in      (q),
      .j_out     (j_out),
      .k_out     (k_out),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   // JK flip-flop bank sharing clk/rst with the sequencer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else begin
         for (int b = 0; b < WIDTH; b++) begin
            case ({j_out[b], k_out[b]})
               2'b10:   q[b] <= 1'b1;
               2'b01:   q[b] <= 1'b0;
               2'b11:   q[b] <= ~q[b];
               default: q[b] <= q[b];
            endcase
         end
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      logic [7:0] data;
      logic [7:0] cnt;
      logic [7:0] exp_q;
      logic       exp_err;
      int         exp_lat;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one command starting at a negedge with the DUT idle, wait for done,
   // check latency/err/bank, then return at the negedge of the following IDLE.
   task automatic run_cmd(input vec_t v, input int idx);
      int lat;
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_data  = v.data;
      cmd_count = v.cnt;
      chk($sformatf("v%0d ready", idx), 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      lat = 1;
      while (!done && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
      chk($sformatf("v%0d q", idx), 32'(q), 32'(v.exp_q));
      chk($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d done_low", idx), 32'(done), 32'd0);
      chk($sformatf("v%0d ready_after", idx), 32'(cmd_ready), 32'd1);
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [7:0] data,
                               input logic [7:0] cnt, input logic [7:0] eq,
                               input logic ee, input int el);
      vec_t v;
      v.op = op; v.data = data; v.cnt = cnt;
      v.exp_q = eq; v.exp_err = ee; v.exp_lat = el;
      return v;
   endfunction

   initial begin
      vecs[0]  = mk(3'd1, 8'hA5, 8'd0, 8'hA5, 1'b0, 2); // LOAD A5
      vecs[1]  = mk(3'd1, 8'h0F, 8'd9, 8'h0F, 1'b0, 2); // LOAD 0F, count ignored
      vecs[2]  = mk(3'd4, 8'h3C, 8'd0, 8'h33, 1'b0, 2); // TOGGLE 3C
      vecs[3]  = mk(3'd2, 8'h00, 8'd0, 8'h00, 1'b0, 2); // CLEAR
      vecs[4]  = mk(3'd3, 8'h00, 8'd0, 8'hFF, 1'b0, 2); // SET
      vecs[5]  = mk(3'd5, 8'h00, 8'd0, 8'hFF, 1'b0, 1); // COUNT 0
      vecs[6]  = mk(3'd7, 8'h12, 8'd4, 8'hFF, 1'b1, 1); // reserved
      vecs[7]  = mk(3'd0, 8'h00, 8'd4, 8'hFF, 1'b0, 1); // NOP
      vecs[8]  = mk(3'd5, 8'h00, 8'd2, 8'h01, 1'b0, 3); // COUNT 2 wraps FF->00->01
      vecs[9]  = mk(3'd1, 8'h00, 8'd0, 8'h00, 1'b0, 2); // LOAD 00
`ifdef JK_BANK_SEQ_SHIFT_EN
      vecs[10] = mk(3'd6, 8'h01, 8'd3, 8'h07, 1'b0, 4); // SHIFT in 1 x3
      vecs[11] = mk(3'd6, 8'h00, 8'd2, 8'h1C, 1'b0, 3); // SHIFT in 0 x2
`else
      vecs[10] = mk(3'd6, 8'h01, 8'd3, 8'h00, 1'b1, 1); // SHIFT as reserved
      vecs[11] = mk(3'd6, 8'h00, 8'd2, 8'h00, 1'b1, 1);
`endif

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_data  = '0;
      cmd_count = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset ready", 32'(cmd_ready), 32'd1);
      chk("reset busy",  32'(busy), 32'd0);
      chk("reset done",  32'(done), 32'd0);
      chk("reset err",   32'(err), 32'd0);
      chk("reset j",     32'(j_out), 32'd0);
      chk("reset k",     32'(k_out), 32'd0);

      for (int i = 0; i < 12; i++) begin
         run_cmd(vecs[i], i);
      end

      // LOAD FE then COUNT 3, bank checked on every edge; meanwhile a LOAD
      // presented while busy must not be captured.
      run_cmd(mk(3'd1, 8'hFE, 8'd0, 8'hFE, 1'b0, 2), 20);
      cmd_valid = 1'b1; cmd_op = 3'd5; cmd_data = 8'h00; cmd_count = 8'd3;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);                           // RUN cycle 1
      chk("cnt c1 j", 32'(j_out), 32'h01);
      chk("cnt c1 k", 32'(k_out), 32'h01);
      chk("cnt c1 ready", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 8'h55;
      @(negedge clk);                           // cycle 2
      chk("cnt c2 q", 32'(q), 32'hFF);
      chk("cnt c2 done", 32'(done), 32'd0);
      @(negedge clk);                           // cycle 3
      chk("cnt c3 q", 32'(q), 32'h00);
      chk("cnt c3 done", 32'(done), 32'd0);
      @(negedge clk);                           // cycle 4 (DONE)
      chk("cnt c4 q", 32'(q), 32'h01);
      chk("cnt c4 done", 32'(done), 32'd1);
      chk("cnt c4 j", 32'(j_out), 32'h00);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("held cmd ignored q", 32'(q), 32'h01);
      chk("idle ready", 32'(cmd_ready), 32'd1);

      // COUNT 200 aborted by reset in RUN cycle 5
      cmd_valid = 1'b1; cmd_op = 3'd5; cmd_data = 8'h00; cmd_count = 8'd200;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort pre q", 32'(q), 32'h05);
      chk("abort pre busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort j", 32'(j_out), 32'd0);
      chk("abort k", 32'(k_out), 32'd0);
      chk("abort ready", 32'(cmd_ready), 32'd1);
      chk("abort done", 32'(done), 32'd0);
      chk("abort q", 32'(q), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("post abort done c%0d", c), 32'(done), 32'd0);
         chk($sformatf("post abort q c%0d", c), 32'(q), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
